// File: rtl/tqvp_pad_pkg.sv
// Shared definitions for the multi-pad NES/SNES poller.
// Register map, control bits, FSM states and pad modes.
package tqvp_pad_pkg;

    localparam int MAX_PADS = 4;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_EVT    = 4'h2;
    localparam logic [3:0] ADDR_MODE   = 4'h3;
    localparam logic [3:0] ADDR_IRQ_EN = 4'h4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_TRIG = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    localparam logic MODE_NES  = 1'b0;
    localparam logic MODE_SNES = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } pad_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tqvp_pad_chan.sv
// One pad channel: serial capture, committed buttons, press events.
// The shift register is only published on the commit strobe.
module tqvp_pad_chan
    import tqvp_pad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pad_bit,
    input  logic        sample,
    input  logic [3:0]  bit_idx,
    input  logic        commit,
    input  logic        clear,
    input  logic        mode,
    output logic [15:0] buttons,
    output logic        evt
);

    logic [15:0] shreg;
    logic [15:0] btn_next;
    logic        pressed;

    assign btn_next = (mode == MODE_SNES) ? shreg : {8'h00, shreg[7:0]};
    assign pressed  = |(btn_next & ~buttons);

    // Capture the inverted pad bit at the current bit position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (sample) begin
            shreg[bit_idx] <= ~pad_bit;
        end
    end

    // Publish a whole frame at once and latch newly pressed buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons <= '0;
            evt     <= 1'b0;
        end else begin
            if (commit) begin
                buttons <= btn_next;
            end
            evt <= (evt & ~clear) | (commit & pressed);
        end
    end

endmodule

// File: rtl/tqvp_multi_pad_poller.sv
// TinyQV byte-register peripheral polling up to four NES/SNES pads.
// Shared latch/clock timing FSM, auto-poll timer and register file.
module tqvp_multi_pad_poller
    import tqvp_pad_pkg::*;
#(
    parameter int NUM_PADS  = 2,
    parameter int LATCH_CYC = 768,
    parameter int HALF_CYC  = 384,
    parameter int POLL_CYC  = 1066667
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PADS-1:0] pad_data,
    output logic                pad_latch,
    output logic                pad_clk,
    input  logic [3:0]          address,
    input  logic                data_write,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    output logic                irq
);

    localparam int CNT_MAX = max3(LATCH_CYC, HALF_CYC, POLL_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LATCH_LD = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] POLL_LD  = CNT_W'(POLL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [MAX_PADS-1:0] PAD_MASK = MAX_PADS'((1 << NUM_PADS) - 1);

    pad_state_t state, state_nxt;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] poll_cnt;
    logic [4:0]       bit_idx, bit_idx_nxt;
    logic [4:0]       nbits;

    logic ctrl_en, ctrl_auto;
    logic trig_pend;
    logic frame_done;
    logic nbits16;

    logic [MAX_PADS-1:0] mode_reg;
    logic [MAX_PADS-1:0] mode_frm;
    logic [MAX_PADS-1:0] irq_en;
    logic [MAX_PADS-1:0] evt;
    logic [MAX_PADS-1:0] evt_clr;
    logic [15:0]         btn [MAX_PADS];

    logic wr_ctrl, wr_evt, wr_mode, wr_irq;
    logic en_now;
    logic poll_run, poll_exp;
    logic start;
    logic sample, commit;
    logic busy;
    logic unused_bits;

    assign wr_ctrl = data_write && (address == ADDR_CTRL);
    assign wr_evt  = data_write && (address == ADDR_EVT);
    assign wr_mode = data_write && (address == ADDR_MODE);
    assign wr_irq  = data_write && (address == ADDR_IRQ_EN);

    assign en_now   = wr_ctrl ? data_in[CTRL_EN] : ctrl_en;
    assign poll_run = ctrl_en && ctrl_auto;
    assign poll_exp = poll_run && (poll_cnt == '0);
    assign start    = (state == ST_IDLE) && en_now && (poll_exp || trig_pend);
    assign busy     = (state != ST_IDLE);
    assign nbits    = nbits16 ? 5'd16 : 5'd8;
    assign evt_clr  = wr_evt ? data_in[MAX_PADS-1:0] : '0;

    assign pad_latch = (state == ST_LATCH);
    assign pad_clk   = (state != ST_LOW);
    assign irq       = |(evt & irq_en);

    assign unused_bits = ^{data_in[7:MAX_PADS], mode_frm};

    // Timing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Next-state logic; disabling aborts without any commit.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        sample      = 1'b0;
        commit      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_LATCH;
                    cnt_nxt     = LATCH_LD;
                    bit_idx_nxt = '0;
                end
            end
            ST_LATCH: begin
                if (cnt == '0) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = HALF_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_LOW: begin
                if (cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = ST_HIGH;
                    cnt_nxt   = HALF_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (cnt == '0) begin
                    bit_idx_nxt = bit_idx + 5'd1;
                    cnt_nxt     = HALF_LD;
                    if (bit_idx + 5'd1 == nbits) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_LOW;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_DONE: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (!en_now) begin
            state_nxt = ST_IDLE;
            sample    = 1'b0;
            commit    = 1'b0;
        end
    end

    // Frame length and per-pad modes are frozen at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbits16  <= 1'b0;
            mode_frm <= '0;
        end else if (start) begin
            nbits16  <= |mode_reg;
            mode_frm <= mode_reg;
        end
    end

    // Free-running poll timer, held at reload while not auto-polling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= POLL_LD;
        end else if (!poll_run || poll_cnt == '0) begin
            poll_cnt <= POLL_LD;
        end else begin
            poll_cnt <= poll_cnt - CNT_ONE;
        end
    end

    // Software trigger stays pending until its frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_pend <= 1'b0;
        end else if (wr_ctrl && data_in[CTRL_TRIG]) begin
            trig_pend <= 1'b1;
        end else if (start || !ctrl_en) begin
            trig_pend <= 1'b0;
        end
    end

    // Writable control registers and sticky frame-done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en    <= 1'b0;
            ctrl_auto  <= 1'b0;
            frame_done <= 1'b0;
            mode_reg   <= '0;
            irq_en     <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= data_in[CTRL_EN];
                ctrl_auto <= data_in[CTRL_AUTO];
            end
            if (commit) begin
                frame_done <= 1'b1;
            end else if (wr_ctrl) begin
                frame_done <= 1'b0;
            end
            if (wr_mode) begin
                mode_reg <= data_in[MAX_PADS-1:0] & PAD_MASK;
            end
            if (wr_irq) begin
                irq_en <= data_in[MAX_PADS-1:0] & PAD_MASK;
            end
        end
    end

    for (genvar p = 0; p < MAX_PADS; p++) begin : g_pad
        if (p < NUM_PADS) begin : g_on
            tqvp_pad_chan u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .pad_bit (pad_data[p]),
                .sample  (sample),
                .bit_idx (bit_idx[3:0]),
                .commit  (commit),
                .clear   (evt_clr[p]),
                .mode    (mode_frm[p]),
                .buttons (btn[p]),
                .evt     (evt[p])
            );
        end else begin : g_off
            assign btn[p] = '0;
            assign evt[p] = 1'b0;
        end
    end

    // Read decode; unmapped addresses and bits read zero.
    always_comb begin
        data_out = 8'h00;
        unique case (1'b1)
            address[3]: begin
                if (address[0]) begin
                    data_out = btn[address[2:1]][15:8];
                end else begin
                    data_out = btn[address[2:1]][7:0];
                end
            end
            address == ADDR_CTRL:   data_out = {6'b0, ctrl_auto, ctrl_en};
            address == ADDR_STATUS: data_out = {6'b0, frame_done, busy};
            address == ADDR_EVT:    data_out = {4'b0, evt};
            address == ADDR_MODE:   data_out = {4'b0, mode_reg};
            address == ADDR_IRQ_EN: data_out = {4'b0, irq_en};
            default:                data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_multi_pad_poller.sv
// Directed bench for the multi-pad poller.
// Pad models shift raw words out on latch/clock edges.
module tb_tqvp_multi_pad_poller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pad_data;
    logic       pad_latch, pad_clk;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       irq;

    logic [15:0] pad_raw [2];
    int          pidx = 0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  mode;
        logic [15:0] raw0;
        logic [15:0] raw1;
        logic [15:0] btn0;
        logic [15:0] btn1;
        int          nbits;
    } fvec_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rvec_t;

    fvec_t fv [5];
    rvec_t rv [16];

    tqvp_multi_pad_poller #(
        .NUM_PADS  (2),
        .LATCH_CYC (4),
        .HALF_CYC  (2),
        .POLL_CYC  (200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pidx <= 0;
        else           pidx <= pidx + 1;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pad_data[p] = (pidx < 16) ? pad_raw[p][pidx[3:0]] : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic chk_rd(input string nm, input logic [3:0] a,
                          input logic [7:0] exp);
        @(negedge clk);
        address = a;
        #1;
        chk(nm, {24'h0, data_out}, {24'h0, exp});
    endtask

    // kind: 0 none, 1 EVT w1c at act_at, 2 disable at act_at, 3 reset at act_at
    task automatic run_frame(input logic [7:0] ctrl, input int act_at,
                             input int kind, output int lat,
                             output int pul, output int bc);
        int   n;
        logic prevc;
        lat   = 0;
        pul   = 0;
        bc    = 0;
        prevc = 1'b1;
        n     = 0;
        wr(4'h0, ctrl);
        while (!dut.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start_timeout", n < 400, 1);
        n = 0;
        while (dut.busy && n < 400) begin
            bc++;
            lat += int'(pad_latch);
            if (pad_clk && !prevc) pul++;
            prevc = pad_clk;
            data_write = 1'b0;
            if (bc == act_at && kind == 1) begin
                address = 4'h2; data_in = 8'h01; data_write = 1'b1;
            end
            if (bc == act_at && kind == 2) begin
                address = 4'h0; data_in = 8'h00; data_write = 1'b1;
            end
            if (bc == act_at && kind == 3) begin
                rst_n = 1'b0;
                #1;
                chk("rst_latch", pad_latch, 0);
                chk("rst_clk", pad_clk, 1);
                chk("rst_busy", dut.busy, 0);
                chk("rst_irq", irq, 0);
                break;
            end
            @(negedge clk);
            n++;
        end
        data_write = 1'b0;
        chk("frame_end_timeout", n < 400, 1);
    endtask

    initial begin
        int         lat, pul, bc;
        logic [15:0] old0, old1;
        logic [3:0] eexp;
        int         r [3];
        int         gaps [3];
        int         nr, gap;
        logic       prevl;

        fv[0] = '{4'h0, 16'h007E, 16'hFFFF, 16'h0081, 16'h0000, 8};
        fv[1] = '{4'h2, 16'h007E, 16'hF6FF, 16'h0081, 16'h0900, 16};
        fv[2] = '{4'h3, 16'h5AA5, 16'h1234, 16'hA55A, 16'hEDCB, 16};
        fv[3] = '{4'h1, 16'hFFFF, 16'h00F0, 16'h0000, 16'h000F, 16};
        fv[4] = '{4'h0, 16'hFFFE, 16'hFF7F, 16'h0001, 16'h0080, 8};

        rv[0]  = '{4'h0, 8'h01};
        rv[1]  = '{4'h1, 8'h02};
        rv[2]  = '{4'h2, 8'h01};
        rv[3]  = '{4'h3, 8'h00};
        rv[4]  = '{4'h4, 8'h01};
        rv[5]  = '{4'h5, 8'h00};
        rv[6]  = '{4'h6, 8'h00};
        rv[7]  = '{4'h7, 8'h00};
        rv[8]  = '{4'h8, 8'h01};
        rv[9]  = '{4'h9, 8'h00};
        rv[10] = '{4'hA, 8'h80};
        rv[11] = '{4'hB, 8'h00};
        rv[12] = '{4'hC, 8'h00};
        rv[13] = '{4'hD, 8'h00};
        rv[14] = '{4'hE, 8'h00};
        rv[15] = '{4'hF, 8'h00};

        pad_raw[0] = 16'hFFFF;
        pad_raw[1] = 16'hFFFF;

        repeat (3) @(negedge clk);
        chk("reset_latch", pad_latch, 0);
        chk("reset_clk", pad_clk, 1);
        chk("reset_irq", irq, 0);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) chk_rd("reset_reg", 4'(a), 8'h00);

        old0 = 16'h0;
        old1 = 16'h0;
        for (int i = 0; i < 5; i++) begin
            wr(4'h3, {4'h0, fv[i].mode});
            wr(4'h2, 8'h0F);
            pad_raw[0] = fv[i].raw0;
            pad_raw[1] = fv[i].raw1;
            run_frame(8'h05, 0, 0, lat, pul, bc);
            chk("vec_latch_cycles", lat, 4);
            chk("vec_pulses", pul, fv[i].nbits);
            chk("vec_busy_cycles", bc, 4 + 4 * fv[i].nbits + 1);
            chk_rd("vec_btn0_lo", 4'h8, fv[i].btn0[7:0]);
            chk_rd("vec_btn0_hi", 4'h9, fv[i].btn0[15:8]);
            chk_rd("vec_btn1_lo", 4'hA, fv[i].btn1[7:0]);
            chk_rd("vec_btn1_hi", 4'hB, fv[i].btn1[15:8]);
            chk_rd("vec_status", 4'h1, 8'h02);
            eexp = {2'b00, |(fv[i].btn1 & ~old1), |(fv[i].btn0 & ~old0)};
            chk_rd("vec_evt", 4'h2, {4'h0, eexp});
            chk("vec_irq_off", irq, 0);
            old0 = fv[i].btn0;
            old1 = fv[i].btn1;
        end

        wr(4'h3, 8'h00);
        wr(4'h0, 8'h03);
        nr = 0; gap = 0; prevl = 1'b0;
        for (int c = 0; c < 900 && nr < 3; c++) begin
            @(negedge clk);
            data_write = 1'b0;
            if (pad_latch && !prevl) begin
                r[nr] = c; gaps[nr] = gap; nr++;
            end
            prevl = pad_latch;
            gap = dut.busy ? 0 : gap + 1;
            if (nr == 1 && c == r[0] + 10) begin
                address = 4'h0; data_in = 8'h07; data_write = 1'b1;
            end
        end
        data_write = 1'b0;
        chk("auto_rises", nr, 3);
        chk("trig_frame_offset", r[1] - r[0], 38);
        chk("trig_idle_gap", gaps[1], 1);
        chk("auto_period", r[2] - r[0], 200);
        wr(4'h0, 8'h01);
        for (int k = 0; k < 200 && dut.busy; k++) @(negedge clk);
        chk("auto_stop_idle", dut.busy, 0);

        wr(4'h2, 8'h0F);
        wr(4'h4, 8'h01);
        pad_raw[0] = 16'hFFFF;
        run_frame(8'h05, 0, 0, lat, pul, bc);
        chk_rd("release_evt", 4'h2, 8'h00);
        pad_raw[0] = 16'hFFFE;
        run_frame(8'h05, 0, 0, lat, pul, bc);
        chk_rd("press_evt", 4'h2, 8'h01);
        chk("press_irq", irq, 1);
        wr(4'h2, 8'h01);
        chk_rd("w1c_evt", 4'h2, 8'h00);
        chk("w1c_irq", irq, 0);
        run_frame(8'h05, 0, 0, lat, pul, bc);
        chk_rd("held_evt", 4'h2, 8'h00);
        chk("held_irq", irq, 0);
        pad_raw[0] = 16'hFFFF;
        run_frame(8'h05, 0, 0, lat, pul, bc);
        pad_raw[0] = 16'hFFFE;
        run_frame(8'h05, 37, 1, lat, pul, bc);
        chk_rd("setwins_evt", 4'h2, 8'h01);
        chk("setwins_irq", irq, 1);

        wr(4'h1, 8'hFF);
        for (int i = 0; i < 16; i++) chk_rd("regmap", rv[i].addr, rv[i].exp);

        pad_raw[0] = 16'h0000;
        pad_raw[1] = 16'h0000;
        run_frame(8'h05, 10, 2, lat, pul, bc);
        chk("abort_cycle", bc, 10);
        chk("abort_latch", pad_latch, 0);
        chk("abort_clk", pad_clk, 1);
        chk_rd("abort_btn0_lo", 4'h8, 8'h01);
        chk_rd("abort_btn0_hi", 4'h9, 8'h00);
        chk_rd("abort_btn1_lo", 4'hA, 8'h80);
        chk_rd("abort_status", 4'h1, 8'h00);
        chk_rd("abort_evt", 4'h2, 8'h01);

        wr(4'h3, 8'h03);
        run_frame(8'h05, 20, 3, lat, pul, bc);
        for (int a = 0; a < 16; a++) chk_rd("midrst_reg", 4'(a), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", dut.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
